// File: rtl/tag_directory.sv
`default_nettype none
// ============================================================================
//  Module   : tag_directory
//  Purpose  : N-way set-associative tag directory. Keeps {valid, tag} per way
//             and a pseudo-LRU state per set. Handles lookups, fills and
//             invalidates through one command port. Reports hit way, victim
//             way and victim tag for write-back decisions. Sweeps every set to
//             all-invalid after reset and on flush.
//  Ports    : i_clk, i_reset          clock, async active-high reset
//             i_cmd_valid/o_cmd_ready command handshake
//             i_cmd_op                00 lookup, 01 fill, 10 invalidate, 11 nop
//             i_address, i_tag_in     set index and tag
//             i_cmd_way               fill target way
//             i_flush, o_busy         flush request, sweep in progress
//             o_resp_valid            one-cycle response pulse
//             o_hit, o_hit_way        hit result
//             o_victim_way/valid/tag  replacement candidate
//  Revision : 1.0  initial release
// ============================================================================
module tag_directory #(
  parameter int TAG_ADDR_WIDTH = 8,
  parameter int TAG_LENGTH     = 9,
  parameter int WAYS           = 2,
  localparam int WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [1:0]                i_cmd_op,
  input  logic [TAG_ADDR_WIDTH-1:0] i_address,
  input  logic [TAG_LENGTH-1:0]     i_tag_in,
  input  logic [WAY_W-1:0]          i_cmd_way,
  input  logic                      i_flush,
  output logic                      o_busy,
  output logic                      o_resp_valid,
  output logic                      o_hit,
  output logic [WAY_W-1:0]          o_hit_way,
  output logic [WAY_W-1:0]          o_victim_way,
  output logic                      o_victim_valid,
  output logic [TAG_LENGTH-1:0]     o_victim_tag
);

  localparam int SETS    = 2**TAG_ADDR_WIDTH;
  localparam int ENTRY_W = TAG_LENGTH + 1;
  localparam int WORD_W  = WAYS * ENTRY_W;
  localparam int PLRU_W  = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [1:0] c_OP_LOOKUP = 2'b00;
  localparam logic [1:0] c_OP_FILL   = 2'b01;
  localparam logic [1:0] c_OP_INV    = 2'b10;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_INV_WR = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [TAG_ADDR_WIDTH-1:0] r_idx;
  logic                      w_cmd_ready, w_busy, w_sweep;
  logic                      w_accept, w_lookup_acc, w_fill_acc, w_inv_acc;

  logic [WORD_W-1:0]         r_mem  [SETS];
  logic [PLRU_W-1:0]         r_plru [SETS];
  logic [WORD_W-1:0]         r_rd_word;

  logic [TAG_ADDR_WIDTH-1:0] r_set;
  logic [TAG_LENGTH-1:0]     r_tag;
  logic                      r_lk_pend;
  logic                      w_resp;

  logic [WAYS-1:0]           w_valid, w_match;
  logic [TAG_LENGTH-1:0]     w_tag [WAYS];
  logic                      w_hit;
  logic [WAY_W-1:0]          w_hit_way, w_vict_way;
  logic                      w_vict_valid;
  logic [TAG_LENGTH-1:0]     w_vict_tag;

  logic                      w_wr_en;
  logic [TAG_ADDR_WIDTH-1:0] w_wr_addr;
  logic [WAYS-1:0]           w_way_en;
  logic [WORD_W-1:0]         w_wr_data;

  logic                      w_hit_upd;
  logic [PLRU_W-1:0]         w_plru_hit, w_plru_fill;

  logic                      r_hit_q, r_vict_valid_q;
  logic [WAY_W-1:0]          r_hit_way_q, r_vict_way_q;
  logic [TAG_LENGTH-1:0]     r_vict_tag_q;

  // Mark way w as most recently used: each tree bit on the path points away.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0]  w);
    logic [2:0] q;
    logic [1:0] wx;
    q  = 3'(p);
    wx = 2'(w);
    if (WAYS == 4) begin
      q[0] = ~wx[1];
      if (wx[1]) q[2] = ~wx[0];
      else       q[1] = ~wx[0];
    end else begin
      q[0] = ~wx[0];
    end
    return PLRU_W'(q);
  endfunction

  // Way the PLRU bits currently point at.
  function automatic logic [WAY_W-1:0] plru_way(input logic [PLRU_W-1:0] p);
    logic [2:0] q;
    logic [1:0] v;
    q = 3'(p);
    if (WAYS == 4)      v = q[0] ? {1'b1, q[2]} : {1'b0, q[1]};
    else if (WAYS == 2) v = {1'b0, q[0]};
    else                v = 2'b00;
    return WAY_W'(v);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sweep) r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_busy      = 1'b0;
    w_sweep     = 1'b0;
    case (r_state)
      S_INIT, S_FLUSH: begin
        w_busy  = 1'b1;
        w_sweep = 1'b1;
        if (&r_idx) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_cmd_ready = !i_flush;
        if (i_flush)
          w_state_nxt = S_FLUSH;
        else if (i_cmd_valid && i_cmd_op == c_OP_INV)
          w_state_nxt = S_INV_WR;
      end
      S_INV_WR: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  assign w_accept     = i_cmd_valid && w_cmd_ready;
  assign w_lookup_acc = w_accept && (i_cmd_op == c_OP_LOOKUP);
  assign w_fill_acc   = w_accept && (i_cmd_op == c_OP_FILL);
  assign w_inv_acc    = w_accept && (i_cmd_op == c_OP_INV);

  // ------------------------------------------------------ read-word decode
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_valid[g] = r_rd_word[g*ENTRY_W + TAG_LENGTH];
    assign w_tag[g]   = r_rd_word[g*ENTRY_W +: TAG_LENGTH];
    assign w_match[g] = w_valid[g] && (w_tag[g] == r_tag);
  end

  always_comb begin
    w_hit      = |w_match;
    w_hit_way  = '0;
    w_vict_way = plru_way(r_plru[r_set]);
    // Descending scan so the lowest index wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w])  w_hit_way  = WAY_W'(w);
      if (!w_valid[w]) w_vict_way = WAY_W'(w);
    end
    w_vict_valid = w_valid[w_vict_way];
    w_vict_tag   = w_tag[w_vict_way];
  end

  // ------------------------------------------------------------ RAM write
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_idx;
    w_way_en  = '0;
    w_wr_data = '0;
    if (w_sweep) begin
      w_wr_en  = 1'b1;
      w_way_en = '1;
    end else if (w_fill_acc) begin
      w_wr_en   = 1'b1;
      w_wr_addr = i_address;
      w_way_en  = WAYS'(1) << i_cmd_way;
      for (int w = 0; w < WAYS; w++)
        w_wr_data[w*ENTRY_W +: ENTRY_W] = {1'b1, i_tag_in};
    end else if (r_state == S_INV_WR && w_hit) begin
      // Only the valid bit is cleared; the stale tag stays in place.
      w_wr_en   = 1'b1;
      w_wr_addr = r_set;
      w_way_en  = WAYS'(1) << w_hit_way;
      for (int w = 0; w < WAYS; w++)
        w_wr_data[w*ENTRY_W +: ENTRY_W] = {1'b0, w_tag[w]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int w = 0; w < WAYS; w++)
        if (w_way_en[w])
          r_mem[w_wr_addr][w*ENTRY_W +: ENTRY_W] <= w_wr_data[w*ENTRY_W +: ENTRY_W];
    end
    if (w_lookup_acc || w_inv_acc) r_rd_word <= r_mem[i_address];
  end

  // ---------------------------------------------------------------- PLRU
  // A hit from the previous lookup and a fill accepted now may target the
  // same set on the same edge; the fill is the later access, so it is
  // applied on top of the hit update.
  assign w_hit_upd   = r_lk_pend && w_hit;
  assign w_plru_hit  = plru_touch(r_plru[r_set], w_hit_way);
  assign w_plru_fill = plru_touch((w_hit_upd && r_set == i_address) ? w_plru_hit
                                                                    : r_plru[i_address],
                                  i_cmd_way);

  always_ff @(posedge i_clk) begin
    if (w_sweep) begin
      r_plru[r_idx] <= '0;
    end else begin
      if (w_hit_upd)  r_plru[r_set]     <= w_plru_hit;
      if (w_fill_acc) r_plru[i_address] <= w_plru_fill;
    end
  end

  // ------------------------------------------------- response and holding
  assign w_resp = r_lk_pend || (r_state == S_INV_WR);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lk_pend      <= 1'b0;
      r_set          <= '0;
      r_tag          <= '0;
      r_hit_q        <= 1'b0;
      r_hit_way_q    <= '0;
      r_vict_way_q   <= '0;
      r_vict_valid_q <= 1'b0;
      r_vict_tag_q   <= '0;
    end else begin
      r_lk_pend <= w_lookup_acc;
      if (w_lookup_acc || w_inv_acc) begin
        r_set <= i_address;
        r_tag <= i_tag_in;
      end
      if (w_resp) begin
        r_hit_q     <= w_hit;
        r_hit_way_q <= w_hit_way;
      end
      if (r_lk_pend) begin
        r_vict_way_q   <= w_vict_way;
        r_vict_valid_q <= w_vict_valid;
        r_vict_tag_q   <= w_vict_tag;
      end
    end
  end

  assign o_cmd_ready    = w_cmd_ready;
  assign o_busy         = w_busy;
  assign o_resp_valid   = w_resp;
  assign o_hit          = w_resp    ? w_hit        : r_hit_q;
  assign o_hit_way      = w_resp    ? w_hit_way    : r_hit_way_q;
  assign o_victim_way   = r_lk_pend ? w_vict_way   : r_vict_way_q;
  assign o_victim_valid = r_lk_pend ? w_vict_valid : r_vict_valid_q;
  assign o_victim_tag   = r_lk_pend ? w_vict_tag   : r_vict_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_tag_directory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tag_directory
//  Purpose  : Self-checking bench for tag_directory (8 set bits, 9-bit tags,
//             2 ways). Directed scenarios plus random command streams checked
//             against a per-set reference model (valid/tag per way, LRU way).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tag_directory;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] addr;
  logic [8:0] tag_in;
  logic       cmd_way;
  logic       flush, busy;
  logic       resp_valid, hit, hit_way, victim_way, victim_valid;
  logic [8:0] victim_tag;

  always #5 clk = ~clk;

  tag_directory #(.TAG_ADDR_WIDTH(8), .TAG_LENGTH(9), .WAYS(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_address(addr), .i_tag_in(tag_in), .i_cmd_way(cmd_way),
    .i_flush(flush), .o_busy(busy), .o_resp_valid(resp_valid), .o_hit(hit),
    .o_hit_way(hit_way), .o_victim_way(victim_way), .o_victim_valid(victim_valid),
    .o_victim_tag(victim_tag)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per set, two ways of {valid, tag}, plus the LRU way.
  bit       m_valid [256][2];
  bit [8:0] m_tag   [256][2];
  bit       m_lru   [256];

  // Expected response of the last modelled command.
  bit       e_rv, e_hit, e_hw, e_vw, e_vv;
  bit [8:0] e_vt;

  // Outputs sampled one step after the accepting edge.
  bit       acc;
  bit       s_rv, s_hit, s_hw, s_vw, s_vv, s_ready_post;
  bit [8:0] s_vt;

  task automatic model_clear();
    for (int s = 0; s < 256; s++) begin
      m_valid[s][0] = 0; m_valid[s][1] = 0;
      m_tag[s][0] = '0;  m_tag[s][1] = '0;
      m_lru[s] = 0;
    end
  endtask

  task automatic model_cmd(input bit [1:0] op, input bit [7:0] a, input bit [8:0] t, input bit w);
    bit h, hw, vw;
    h  = 0; hw = 0;
    if (m_valid[a][0] && m_tag[a][0] == t) begin h = 1; hw = 0; end
    else if (m_valid[a][1] && m_tag[a][1] == t) begin h = 1; hw = 1; end
    e_rv = 0;
    case (op)
      2'b00: begin
        e_rv = 1; e_hit = h; e_hw = hw;
        if (!m_valid[a][0])      vw = 0;
        else if (!m_valid[a][1]) vw = 1;
        else                     vw = m_lru[a];
        e_vw = vw; e_vv = m_valid[a][vw]; e_vt = m_tag[a][vw];
        if (h) m_lru[a] = ~hw;
      end
      2'b01: begin
        m_valid[a][w] = 1; m_tag[a][w] = t; m_lru[a] = ~w;
      end
      2'b10: begin
        e_rv = 1; e_hit = h; e_hw = hw;
        if (h) m_valid[a][hw] = 0;
      end
      default: ;
    endcase
  endtask

  // Drive one command, wait (bounded) for acceptance, sample just after the edge.
  task automatic issue(input bit [1:0] op, input bit [7:0] a, input bit [8:0] t, input bit w);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; addr = a; tag_in = t; cmd_way = w;
    #1;
    while (!cmd_ready && n < 16) begin
      @(negedge clk); #1; n++;
    end
    acc = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 0;
    s_rv = resp_valid; s_hit = hit; s_hw = hit_way; s_vw = victim_way;
    s_vv = victim_valid; s_vt = victim_tag; s_ready_post = cmd_ready;
  endtask

  // Count consecutive busy cycles starting from the current cycle (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1; cmd_valid = 0; cmd_op = 0; addr = 0; tag_in = 0; cmd_way = 0; flush = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, resp_valid, hit, hit_way, victim_way, victim_valid, victim_tag} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b busy=%0b rv=%0b hit=%0b hw=%0b vw=%0b vv=%0b vt=%h, need 0 1 0 0 0 0 0 000",
               cmd_ready, busy, resp_valid, hit, hit_way, victim_way, victim_valid, victim_tag);
    end
    @(negedge clk);
    rst = 0;
    #1;
    count_busy(n);
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL init_busy_cycles: got %0d need 256", n);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_init: got %0b need 1", cmd_ready);
    end
    model_clear();
  endtask

  task automatic test_first_lookup();
    bit [7:0] a;
    a = 8'($urandom_range(0, 255));
    issue(2'b00, a, 9'($urandom), 0);
    model_cmd(2'b00, a, 0, 0);
    checks++;
    if (!acc || {s_rv, s_hit, s_vw, s_vv} !== 4'b1000) begin
      errors++;
      $display("FAIL empty_lookup: got acc=%0b rv=%0b hit=%0b vw=%0b vv=%0b, need 1 1 0 0 0",
               acc, s_rv, s_hit, s_vw, s_vv);
    end
  endtask

  task automatic test_fill_lookup();
    issue(2'b01, 8'd5, 9'h1A3, 0); model_cmd(2'b01, 8'd5, 9'h1A3, 0);
    checks++;
    if (!acc || s_rv !== 1'b0) begin
      errors++; $display("FAIL fill_no_resp: got acc=%0b rv=%0b, need 1 0", acc, s_rv);
    end
    issue(2'b00, 8'd5, 9'h1A3, 0); model_cmd(2'b00, 8'd5, 9'h1A3, 0);
    checks++;
    if ({s_rv, s_hit, s_hw, s_vw, s_vv} !== 5'b11010) begin
      errors++;
      $display("FAIL fill_then_lookup: got rv=%0b hit=%0b hw=%0b vw=%0b vv=%0b, need 1 1 0 1 0",
               s_rv, s_hit, s_hw, s_vw, s_vv);
    end
  endtask

  task automatic test_victim();
    issue(2'b01, 8'd9, 9'h010, 0); model_cmd(2'b01, 8'd9, 9'h010, 0);
    issue(2'b01, 8'd9, 9'h020, 1); model_cmd(2'b01, 8'd9, 9'h020, 1);
    issue(2'b00, 8'd9, 9'h010, 0); model_cmd(2'b00, 8'd9, 9'h010, 0);
    checks++;
    if ({s_rv, s_hit, s_hw} !== 3'b110) begin
      errors++; $display("FAIL set9_hit_way0: got rv=%0b hit=%0b hw=%0b, need 1 1 0", s_rv, s_hit, s_hw);
    end
    issue(2'b00, 8'd9, 9'h030, 0); model_cmd(2'b00, 8'd9, 9'h030, 0);
    checks++;
    if ({s_rv, s_hit, s_vw, s_vv, s_vt} !== {1'b1, 1'b0, 1'b1, 1'b1, 9'h020}) begin
      errors++;
      $display("FAIL plru_victim: got rv=%0b hit=%0b vw=%0b vv=%0b vt=%h, need 1 0 1 1 020",
               s_rv, s_hit, s_vw, s_vv, s_vt);
    end
  endtask

  task automatic test_invalidate();
    issue(2'b10, 8'd9, 9'h020, 0); model_cmd(2'b10, 8'd9, 9'h020, 0);
    checks++;
    if ({s_ready_post, s_rv, s_hit, s_hw} !== 4'b0111) begin
      errors++;
      $display("FAIL invalidate_resp: got ready=%0b rv=%0b hit=%0b hw=%0b, need 0 1 1 1",
               s_ready_post, s_rv, s_hit, s_hw);
    end
    issue(2'b00, 8'd9, 9'h020, 0); model_cmd(2'b00, 8'd9, 9'h020, 0);
    checks++;
    if ({s_rv, s_hit, s_vw, s_vv} !== 4'b1010) begin
      errors++;
      $display("FAIL lookup_after_inv: got rv=%0b hit=%0b vw=%0b vv=%0b, need 1 0 1 0",
               s_rv, s_hit, s_vw, s_vv);
    end
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, hit, victim_way, victim_valid} !== {1'b0, e_hit, e_vw, e_vv}) begin
      errors++;
      $display("FAIL outputs_hold: got rv=%0b hit=%0b vw=%0b vv=%0b, need 0 %0b %0b %0b",
               resp_valid, hit, victim_way, victim_valid, e_hit, e_vw, e_vv);
    end
  endtask

  task automatic test_random();
    bit [1:0] op;
    bit [7:0] a;
    bit [8:0] t;
    bit       w;
    int       r;
    for (int i = 0; i < 500; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      t  = 9'h100 + 9'($urandom_range(0, 3));
      w  = 1'($urandom);
      issue(op, a, t, w);
      model_cmd(op, a, t, w);
      checks++;
      if (!acc || s_rv !== e_rv) begin
        errors++;
        $display("FAIL rnd_resp_valid #%0d op=%0d: got acc=%0b rv=%0b need 1 %0b", i, op, acc, s_rv, e_rv);
      end else if (e_rv) begin
        checks++;
        if (s_hit !== e_hit || (e_hit && s_hw !== e_hw)) begin
          errors++;
          $display("FAIL rnd_hit #%0d op=%0d set=%0d: got hit=%0b hw=%0b need %0b %0b",
                   i, op, a, s_hit, s_hw, e_hit, e_hw);
        end
        if (op == 2'b00) begin
          checks++;
          if (s_vw !== e_vw || s_vv !== e_vv || (e_vv && s_vt !== e_vt)) begin
            errors++;
            $display("FAIL rnd_victim #%0d set=%0d: got vw=%0b vv=%0b vt=%h need %0b %0b %h",
                     i, a, s_vw, s_vv, s_vt, e_vw, e_vv, e_vt);
          end
        end
        if (op == 2'b10) begin
          checks++;
          if (s_ready_post !== 1'b0) begin
            errors++; $display("FAIL rnd_inv_ready #%0d: got %0b need 0", i, s_ready_post);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    int n;
    @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b00; addr = 8'd5; tag_in = 9'h1A3; flush = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_ready: got %0b need 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cmd_dropped: got rv=%0b need 0", resp_valid);
    end
    @(negedge clk);
    cmd_valid = 0; flush = 0;
    #1;
    count_busy(n);
    model_clear();
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL flush_busy_cycles: got %0d need 256", n);
    end
    for (int i = 0; i < 6; i++) begin
      bit [7:0] a;
      a = (i == 0) ? 8'd5 : (i == 1) ? 8'd9 : 8'(i - 2);
      issue(2'b00, a, (i == 0) ? 9'h1A3 : (i == 1) ? 9'h010 : 9'h100 + 9'(i - 2), 0);
      model_cmd(2'b00, a, 0, 0);
      checks++;
      if ({s_rv, s_hit, s_vw, s_vv} !== 4'b1000) begin
        errors++;
        $display("FAIL lookup_after_flush set=%0d: got rv=%0b hit=%0b vw=%0b vv=%0b, need 1 0 0 0",
                 a, s_rv, s_hit, s_vw, s_vv);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int n;
    issue(2'b01, 8'd7, 9'h0AA, 1); model_cmd(2'b01, 8'd7, 9'h0AA, 1);
    issue(2'b00, 8'd7, 9'h0AA, 0); model_cmd(2'b00, 8'd7, 9'h0AA, 0);
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    repeat (100) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({cmd_ready, busy, resp_valid, hit, hit_way, victim_way, victim_valid, victim_tag} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000}) begin
      errors++;
      $display("FAIL midsweep_reset_outputs: got ready=%0b busy=%0b rv=%0b hit=%0b hw=%0b vw=%0b vv=%0b vt=%h, need 0 1 0 0 0 0 0 000",
               cmd_ready, busy, resp_valid, hit, hit_way, victim_way, victim_valid, victim_tag);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    count_busy(n);
    model_clear();
    checks++;
    if (n != 256) begin
      errors++; $display("FAIL midsweep_busy_cycles: got %0d need 256", n);
    end
    issue(2'b00, 8'd7, 9'h0AA, 0); model_cmd(2'b00, 8'd7, 9'h0AA, 0);
    checks++;
    if ({s_rv, s_hit, s_vw, s_vv} !== 4'b1000) begin
      errors++;
      $display("FAIL lookup_after_reset: got rv=%0b hit=%0b vw=%0b vv=%0b, need 1 0 0 0",
               s_rv, s_hit, s_vw, s_vv);
    end
  endtask

  initial begin
    test_reset();
    test_first_lookup();
    test_fill_lookup();
    test_victim();
    test_invalidate();
    test_hold();
    test_random();
    test_flush();
    test_reset_midsweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tag_directory.md
Name: tag_directory

Overview:
- Parametrised, N-way set-associative successor to the single-way tag RAM.
- Stores tag, valid bit per way and pseudo-LRU state per set; answers lookups, accepts fills and invalidates through one command port.
- Sits between the cache controller FSM and the data RAMs; supplies hit way, victim way and victim tag for write-back decisions.
- Clears itself after reset and on Flush by sweeping all sets.

Parameters:
- TAG_ADDR_WIDTH, 8, set index width; 2**TAG_ADDR_WIDTH sets.
- TAG_LENGTH, 9, stored tag width.
- WAYS, 2, associativity; legal values are 1, 2 and 4. WAY_W = max(1, log2(WAYS)) is a localparam.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command request.
- CmdReady  out  1  command accepted when CmdValid && CmdReady at posedge.
- CmdOp  in  2  00 lookup, 01 fill, 10 invalidate, 11 reserved (accepted, no effect, no response).
- Address  in  TAG_ADDR_WIDTH  set index.
- TagIn  in  TAG_LENGTH  tag to compare or store.
- CmdWay  in  WAY_W  target way for fill.
- Flush  in  1  request to clear all valid bits.
- Busy  out  1  init or flush sweep in progress.
- RespValid  out  1  one-cycle pulse carrying a lookup or invalidate result.
- Hit  out  1  tag matched a valid way.
- HitWay  out  WAY_W  matching way, lowest index if more than one matches.
- VictimWay  out  WAY_W  lowest-index invalid way; if all ways are valid, the PLRU way.
- VictimValid  out  1  victim way holds valid data.
- VictimTag  out  TAG_LENGTH  tag stored in the victim way.

Behaviour:
- Storage:
  - Per-set RAM word holds {valid, tag} x WAYS; synchronous read, written on posedge; no reset on the RAM.
  - PLRU bits (WAYS-1 per set) are held in a flop array, also cleared by the sweep. WAYS=1 has no PLRU; VictimWay is always 0.
- States: INIT, IDLE, INV_WR, FLUSH.
- Reset asserted:
  - State goes to INIT, sweep index goes to 0.
  - CmdReady=0, Busy=1, RespValid=0, Hit=0, HitWay=0, VictimWay=0, VictimValid=0, VictimTag=0.
- INIT/FLUSH:
  - Each cycle writes set[index] all-invalid with PLRU=0, then increments index.
  - After writing set 2**TAG_ADDR_WIDTH-1, goes to IDLE. Busy drops in the cycle after the last write, so the sweep takes exactly 2**TAG_ADDR_WIDTH cycles.
  - Flush is ignored during the sweep.
  - Reset mid-sweep restarts the sweep at index 0.
- IDLE:
  - CmdReady = !Flush.
  - Flush in IDLE goes to FLUSH. If Flush and CmdValid arrive together, Flush wins and the command is not accepted.
- Lookup (accepted in cycle N):
  - RAM read at N; RespValid=1 in N+1 with Hit/HitWay/Victim* from the read word and current PLRU.
  - On a hit, PLRU for that set is updated at the end of N+1 so HitWay becomes MRU. A miss leaves PLRU unchanged.
  - Lookups are fully pipelined: one per cycle, CmdReady stays 1.
- Fill:
  - Writes {1, TagIn} into way CmdWay of set Address at the accepting edge; other ways are preserved. The RAM is written as a full word using byte-lane-style way enables.
  - CmdWay becomes MRU. No response. One per cycle.
  - A lookup in the next cycle to the same set sees the fill.
  - Duplicate tags are not checked.
- Invalidate:
  - Read at accept; goes to INV_WR with CmdReady=0 for one cycle.
  - In INV_WR: compare; if hit, clear the valid bit of HitWay. PLRU unchanged. RespValid=1 with Hit/HitWay. Return to IDLE.
- PLRU:
  - WAYS=2: one bit that points to the LRU way.
  - WAYS=4: 3-bit tree. Bit0 selects the half; bit1 or bit2 selects the way within that half. Bits point away from the last accessed way.
- Outputs other than RespValid hold their value between responses.

Test Plan:
- Release reset; count Busy cycles -> Busy=1 for exactly 256 cycles, then CmdReady=1. Lookup of any set then returns Hit=0, VictimWay=0, VictimValid=0.
- Fill set 5 way 0 tag 0x1A3, then immediately look up set 5 tag 0x1A3 -> RespValid next cycle, Hit=1, HitWay=0, VictimWay=1, VictimValid=0.
- Fill set 9 way0=0x010 and way1=0x020, look up 0x010, then look up 0x030 -> second response Hit=0, VictimWay=1, VictimValid=1, VictimTag=0x020.
- Invalidate set 9 tag 0x020 -> CmdReady=0 for one cycle, RespValid with Hit=1, HitWay=1. A following lookup of 0x020 gives Hit=0, VictimWay=1, VictimValid=0.
- Assert Flush in the same cycle as a lookup CmdValid -> command not accepted, Busy=1 for 256 cycles, all previously filled tags miss afterwards.
- Assert Reset at sweep index 100, release it -> Busy=1 for a full 256 cycles from release. Outputs are 0 while Reset is high.
